// File: rtl/load_store_unit.sv
// Purpose: MIPS byte/half/word load-store unit between the EX stage and a word-wide data memory.
// Latency: error resp 1 cycle after accept, SW 2, loads 3, SB/SH 4 (read-modify-write).
// Backpressure: one op in flight, ready only in IDLE; responses are pulses with no stall.
`timescale 1ns/1ps
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [5:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        ready,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] load_data,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [31:0] mem_rdata
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, RESP} state_t;

  state_t      state;
  logic [5:0]  op_q;
  logic [1:0]  addr_q;    // only the byte offset matters once mem_addr is registered
  logic [15:0] wdata_q;   // only SB/SH need store data after the read phase

  logic        req_bad;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext_data;
  logic [31:0] merged;

  // Reject unsupported opcodes and misaligned halfword/word accesses at accept time
  always_comb begin
    req_bad = 1'b0;
    case (req_op)
      OP_LB, OP_LBU, OP_SB: req_bad = 1'b0;
      OP_LH, OP_LHU, OP_SH: req_bad = req_addr[0];
      OP_LW, OP_SW:         req_bad = |req_addr[1:0];
      default:              req_bad = 1'b1;
    endcase
  end

  // Big-endian lane extraction for loads and lane merge for sub-word stores
  always_comb begin
    case (addr_q)
      2'd0:    byte_sel = mem_rdata[31:24];
      2'd1:    byte_sel = mem_rdata[23:16];
      2'd2:    byte_sel = mem_rdata[15:8];
      default: byte_sel = mem_rdata[7:0];
    endcase
    half_sel = addr_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];

    case (op_q)
      OP_LB:   ext_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  ext_data = {24'h0, byte_sel};
      OP_LH:   ext_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  ext_data = {16'h0, half_sel};
      default: ext_data = mem_rdata;
    endcase

    merged = mem_rdata;
    if (op_q == OP_SB) begin
      case (addr_q)
        2'd0:    merged[31:24] = wdata_q[7:0];
        2'd1:    merged[23:16] = wdata_q[7:0];
        2'd2:    merged[15:8]  = wdata_q[7:0];
        default: merged[7:0]   = wdata_q[7:0];
      endcase
    end else if (op_q == OP_SH) begin
      if (addr_q[1]) merged[15:0]  = wdata_q;
      else           merged[31:16] = wdata_q;
    end
  end

  // Control FSM; every output is registered on state entry so strobes are glitch-free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= 6'h0;
      addr_q     <= 2'h0;
      wdata_q    <= 16'h0;
      ready      <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      load_data  <= 32'h0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q    <= req_op;
            addr_q  <= req_addr[1:0];
            wdata_q <= req_wdata[15:0];
            ready   <= 1'b0;
            if (req_bad) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              load_data  <= 32'h0;
            end else if (req_op == OP_SW) begin
              state     <= WRITE;
              mem_wr    <= 1'b1;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wdata <= req_wdata;
            end else begin
              state    <= READ;
              mem_rd   <= 1'b1;
              mem_addr <= {req_addr[31:2], 2'b00};
            end
          end
        end
        READ: state <= CAPTURE;
        CAPTURE: begin
          if (op_q == OP_SB || op_q == OP_SH) begin
            state     <= WRITE;
            mem_wr    <= 1'b1;
            mem_wdata <= merged;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            load_data  <= ext_data;
          end
        end
        WRITE: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          load_data  <= 32'h0;
        end
        RESP: begin
          state <= IDLE;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed vectors, a back-to-back random run
// against a lane-shift reference model, and reset abandonment during a write.
`timescale 1ns/1ps
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic [5:0]  req_op = 6'h0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        ready, resp_valid, resp_err, mem_rd, mem_wr;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .ready(ready), .resp_valid(resp_valid), .resp_err(resp_err), .load_data(load_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        err;
    logic [31:0] data;
    logic [31:0] wd;
    logic [31:0] wa;
    int          due;
    int          nrd;
    int          nwr;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [0:255];
  logic [31:0] model_mem [0:255];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;

  function automatic logic [31:0] init_word(input int i);
    if (i == 'h40) return 32'h8899AABB;
    return 32'hA5000000 ^ (i * 32'h01030507);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Data memory: read data appears the cycle after the mem_rd cycle
  initial for (int i = 0; i < 256; i++) mem[i] = init_word(i);
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr[9:2]];
    if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: strobes and responses checked against the head of the scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      if (mem_rd || mem_wr) begin
        check("strobe_excl", {31'h0, mem_rd & mem_wr}, 32'h0);
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL stray_strobe: rd=%0b wr=%0b with nothing outstanding", mem_rd, mem_wr);
        end else begin
          check("mem_addr", mem_addr, sb[0].wa);
          if (mem_wr) check("mem_wdata", mem_wdata, sb[0].wd);
        end
      end
      if (mem_rd) rd_cnt++;
      if (mem_wr) wr_cnt++;
      if (resp_valid) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL stray_resp: resp_valid=1 with nothing outstanding");
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("resp_err", {31'h0, resp_err}, {31'h0, e.err});
          if (!e.err) check("load_data", load_data, e.data);
          check("resp_edge", cyc + 1, e.due);
          check("rd_pulses", rd_cnt, e.nrd);
          check("wr_pulses", wr_cnt, e.nwr);
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
    end
  end

  // Latency and strobe counts per op class; e.due holds latency until drive() makes it absolute
  function automatic exp_t shape(input logic [5:0] op, input logic [31:0] addr, input logic err);
    exp_t e;
    e = '{default: 0};
    e.err = err;
    e.wa  = {addr[31:2], 2'b00};
    if (err) begin
      e.due = 1; e.nrd = 0; e.nwr = 0;
    end else begin
      case (op)
        6'h2B:        begin e.due = 2; e.nrd = 0; e.nwr = 1; end
        6'h28, 6'h29: begin e.due = 4; e.nrd = 1; e.nwr = 1; end
        default:      begin e.due = 3; e.nrd = 1; e.nwr = 0; end
      endcase
    end
    return e;
  endfunction

  // Reference model: lanes found by shifting the word right by the big-endian lane distance
  function automatic exp_t model(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    logic [31:0] w, mask;
    logic [7:0]  b;
    logic [15:0] h;
    logic        err;
    int          bsh, hsh;
    w   = model_mem[addr[9:2]];
    bsh = 8 * (3 - int'(addr[1:0]));
    hsh = addr[1] ? 0 : 16;
    b   = 8'(w >> bsh);
    h   = 16'(w >> hsh);
    case (op)
      6'h20, 6'h24, 6'h28: err = 1'b0;
      6'h21, 6'h25, 6'h29: err = addr[0];
      6'h23, 6'h2B:        err = |addr[1:0];
      default:             err = 1'b1;
    endcase
    e = shape(op, addr, err);
    if (!err) begin
      case (op)
        6'h20: e.data = {{24{b[7]}}, b};
        6'h24: e.data = {24'h0, b};
        6'h21: e.data = {{16{h[15]}}, h};
        6'h25: e.data = {16'h0, h};
        6'h23: e.data = w;
        6'h28: begin mask = 32'hFF << bsh;   e.wd = (w & ~mask) | ({24'h0, wd[7:0]} << bsh); end
        6'h29: begin mask = 32'hFFFF << hsh; e.wd = (w & ~mask) | ({16'h0, wd[15:0]} << hsh); end
        default: e.wd = wd;
      endcase
    end
    return e;
  endfunction

  // Present one request when ready, record its expectation after the accept edge
  task automatic drive(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input exp_t e_in, input bit keep, input bit push);
    exp_t e;
    int   guard;
    e = e_in;
    guard = 0;
    @(negedge clk);
    while (!ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!ready) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: ready=%0b want 1", ready);
      req_valid = 1'b0;
      return;
    end
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk);
    #1;
    e.due = cyc + e.due;
    if (push) begin
      if (!e.err && e.nwr > 0) model_mem[addr[9:2]] = e.wd;
      sb.push_back(e);
    end
    if (!keep) req_valid = 1'b0;
  endtask

  // Directed op with hand-computed load result (data) or memory word after the store (wword)
  task automatic dir(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                     input logic err, input logic [31:0] data, input logic [31:0] wword);
    exp_t e;
    e = shape(op, addr, err);
    e.data = data;
    e.wd   = wword;
    drive(op, addr, wd, e, 1'b0, 1'b1);
  endtask

  // Stimulus
  initial begin
    logic [5:0]  ops [9];
    logic [5:0]  op;
    logic [31:0] addr, wd;
    exp_t        e;
    int          g;
    ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h22};
    for (int i = 0; i < 256; i++) model_mem[i] = init_word(i);

    #1 rst_n = 1'b0;
    #2;
    check("rst_ready", {31'h0, ready}, 32'h1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_resp_err", {31'h0, resp_err}, 32'h0);
    check("rst_load_data", load_data, 32'h0);
    check("rst_mem_rd", {31'h0, mem_rd}, 32'h0);
    check("rst_mem_wr", {31'h0, mem_wr}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Word 0x100 holds 0x8899AABB: bytes 88,99,AA,BB at offsets 0..3
    dir(6'h20, 32'h101, 32'h0,        1'b0, 32'hFFFFFF99, 32'h0);
    dir(6'h24, 32'h101, 32'h0,        1'b0, 32'h00000099, 32'h0);
    dir(6'h21, 32'h100, 32'h0,        1'b0, 32'hFFFF8899, 32'h0);
    dir(6'h25, 32'h102, 32'h0,        1'b0, 32'h0000AABB, 32'h0);
    dir(6'h23, 32'h100, 32'h0,        1'b0, 32'h8899AABB, 32'h0);
    dir(6'h24, 32'h103, 32'h0,        1'b0, 32'h000000BB, 32'h0);
    dir(6'h21, 32'h102, 32'h0,        1'b0, 32'hFFFFAABB, 32'h0);
    dir(6'h28, 32'h103, 32'h12345677, 1'b0, 32'h0,        32'h8899AA77);
    dir(6'h23, 32'h100, 32'h0,        1'b0, 32'h8899AA77, 32'h0);
    dir(6'h2B, 32'h100, 32'h8899AABB, 1'b0, 32'h0,        32'h8899AABB);
    dir(6'h29, 32'h100, 32'h00001234, 1'b0, 32'h0,        32'h1234AABB);
    dir(6'h20, 32'h100, 32'h0,        1'b0, 32'h00000012, 32'h0);
    dir(6'h23, 32'h102, 32'h0,        1'b1, 32'h0,        32'h0);
    dir(6'h22, 32'h100, 32'h0,        1'b1, 32'h0,        32'h0);
    dir(6'h29, 32'h101, 32'hFFFF,     1'b1, 32'h0,        32'h0);
    dir(6'h2B, 32'h106, 32'hFFFF,     1'b1, 32'h0,        32'h0);
    dir(6'h25, 32'h103, 32'h0,        1'b1, 32'h0,        32'h0);

    // Back-to-back random ops with req_valid never dropped
    for (int i = 0; i < 50; i++) begin
      op   = ops[$urandom_range(0, 8)];
      addr = 32'h100 + 32'($urandom_range(0, 31));
      wd   = $urandom;
      e    = model(op, addr, wd);
      drive(op, addr, wd, e, 1'b1, 1'b1);
    end
    req_valid = 1'b0;

    g = 0;
    while (sb.size() != 0 && g < 30) begin
      @(negedge clk);
      g++;
    end
    check("drain_outstanding", sb.size(), 0);

    // Reset in the middle of a SW: the write strobe must drop at once and memory stay intact
    e = shape(6'h2B, 32'h140, 1'b0);
    drive(6'h2B, 32'h140, 32'hDEADBEEF, e, 1'b0, 1'b0);
    check("wr_before_rst", {31'h0, mem_wr}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("wr_async_drop", {31'h0, mem_wr}, 32'h0);
    check("rst_mid_ready", {31'h0, ready}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_mem_kept", mem[8'h50], init_word('h50));
    check("post_rst_ready", {31'h0, ready}, 32'h1);

    for (int i = 'h40; i < 'h48; i++) check("mem_final", mem[i], model_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
